hilo_div_unit: RTL and testbench

HI/LO register pair with an attached iterative 32-bit divider. It sits beside the execute-stage ALU: it takes the ALU's 64-bit HI/LO write (mult/multu/mthi/mtlo), returns the current {HI,LO} to the ALU's hilo input for mfhi/mflo/mthi/mtlo, and executes div/divu as a multi-cycle operation. While a divide is in flight it raises a stall to the pipeline.

---
 rtl/mips_hilo_pkg.sv | 22 ++
 rtl/hilo_div_core.sv | 139 +++++++++++++
 rtl/hilo_div_unit.sv | 68 ++++++
 tb/tb_hilo_div_unit.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/mips_hilo_pkg.sv
// Shared types and constants for the HI/LO register pair and its iterative divider.
package mips_hilo_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        PREP = 2'd1,
        RUN  = 2'd2,
        FIX  = 2'd3
    } div_state_e;

    localparam int DIV_ITER = 32;
    localparam int HILO_W   = 64;
    localparam int HI_MSB   = 63;
    localparam int HI_LSB   = 32;
    localparam int LO_MSB   = 31;
    localparam int LO_LSB   = 0;

    function automatic logic [31:0] abs32(input logic [31:0] v, input logic is_signed);
        abs32 = (is_signed && v[31]) ? -v : v;
    endfunction

endpackage

// File: rtl/hilo_div_core.sv
// Restoring 32-bit divider: operand latch, magnitude/sign prep, one quotient bit
// per RUN cycle, sign fix-up in FIX. Divide-by-zero skips RUN entirely.
module hilo_div_core
    import mips_hilo_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_start,
    input  logic             i_flush,
    input  logic             i_signed,
    input  logic [DIV_W-1:0] i_a,
    input  logic [DIV_W-1:0] i_b,
    output logic             o_busy,
    output logic             o_in_fix,
    output logic             o_done,
    output logic             o_by_zero,
    output logic             o_wr,
    output logic [DIV_W-1:0] o_quo,
    output logic [DIV_W-1:0] o_rem
);

    localparam int CNT_W = $clog2(DIV_ITER);

    div_state_e         r_state;
    div_state_e         w_next;
    logic [DIV_W-1:0]   r_a;
    logic [DIV_W-1:0]   r_b;
    logic               r_signed;
    logic               r_sign_q;
    logic               r_sign_r;
    logic               r_dbz;
    logic [DIV_W-1:0]   r_quo;
    logic [DIV_W-1:0]   r_rem;
    logic [DIV_W-1:0]   r_divisor;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIV_W:0]     w_rem_sh;
    logic [DIV_W:0]     w_trial;
    logic               w_accept;

    assign w_accept = i_start && !i_flush;
    assign w_rem_sh = {r_rem, r_quo[DIV_W-1]};
    assign w_trial  = w_rem_sh - {1'b0, r_divisor};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; flush wins everywhere, including over a new start
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) w_next = PREP;
                else          w_next = IDLE;
            end
            PREP: begin
                if (i_flush)                     w_next = IDLE;
                else if (r_b == {DIV_W{1'b0}})   w_next = FIX;
                else                             w_next = RUN;
            end
            RUN: begin
                if (i_flush)                        w_next = IDLE;
                else if (r_cnt == CNT_W'(DIV_ITER-1)) w_next = FIX;
                else                                w_next = RUN;
            end
            FIX:     w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // Divider datapath: operand capture, magnitude prep and the restoring step
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_a       <= {DIV_W{1'b0}};
            r_b       <= {DIV_W{1'b0}};
            r_signed  <= 1'b0;
            r_sign_q  <= 1'b0;
            r_sign_r  <= 1'b0;
            r_dbz     <= 1'b0;
            r_quo     <= {DIV_W{1'b0}};
            r_rem     <= {DIV_W{1'b0}};
            r_divisor <= {DIV_W{1'b0}};
            r_cnt     <= {CNT_W{1'b0}};
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_a      <= i_a;
                        r_b      <= i_b;
                        r_signed <= i_signed;
                    end else begin
                        r_a      <= r_a;
                        r_b      <= r_b;
                        r_signed <= r_signed;
                    end
                end
                PREP: begin
                    r_quo     <= abs32(r_a, r_signed);
                    r_divisor <= abs32(r_b, r_signed);
                    r_sign_q  <= r_signed & (r_a[DIV_W-1] ^ r_b[DIV_W-1]);
                    r_sign_r  <= r_signed & r_a[DIV_W-1];
                    r_dbz     <= (r_b == {DIV_W{1'b0}});
                    r_rem     <= {DIV_W{1'b0}};
                    r_cnt     <= {CNT_W{1'b0}};
                end
                RUN: begin
                    // Remainder never exceeds the divisor, so the low DIV_W bits suffice
                    if (!w_trial[DIV_W]) begin
                        r_rem <= w_trial[DIV_W-1:0];
                        r_quo <= {r_quo[DIV_W-2:0], 1'b1};
                    end else begin
                        r_rem <= w_rem_sh[DIV_W-1:0];
                        r_quo <= {r_quo[DIV_W-2:0], 1'b0};
                    end
                    r_cnt <= r_cnt + CNT_W'(1);
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign o_busy    = (r_state != IDLE);
    assign o_in_fix  = (r_state == FIX);
    assign o_done    = o_in_fix && !i_flush;
    assign o_by_zero = o_in_fix && r_dbz && !i_flush;
    assign o_wr      = o_in_fix && !r_dbz && !i_flush;
    assign o_quo     = r_sign_q ? -r_quo : r_quo;
    assign o_rem     = r_sign_r ? -r_rem : r_rem;

endmodule

// File: rtl/hilo_div_unit.sv
// HI/LO register pair with attached multi-cycle divider.
// Optional HILO_WR_BYPASS_EN forwards an ALU write to hilo_out in the same cycle.
module hilo_div_unit
    import mips_hilo_pkg::*;
#(
    parameter int DIV_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              hilo_we,
    input  logic [HILO_W-1:0] hilo_wdata,
    input  logic              div_start,
    input  logic              div_signed,
    input  logic [DIV_W-1:0]  div_a,
    input  logic [DIV_W-1:0]  div_b,
    input  logic              flush,
    output logic [HILO_W-1:0] hilo_out,
    output logic              div_busy,
    output logic              div_done,
    output logic              div_by_zero
);

    logic [HILO_W-1:0] r_hilo;
    logic              w_div_wr;
    logic              w_in_fix;
    logic [DIV_W-1:0]  w_quo;
    logic [DIV_W-1:0]  w_rem;

    hilo_div_core #(
        .DIV_W (DIV_W)
    ) u_core (
        .clk       (clk),
        .rst       (rst),
        .i_start   (div_start),
        .i_flush   (flush),
        .i_signed  (div_signed),
        .i_a       (div_a),
        .i_b       (div_b),
        .o_busy    (div_busy),
        .o_in_fix  (w_in_fix),
        .o_done    (div_done),
        .o_by_zero (div_by_zero),
        .o_wr      (w_div_wr),
        .o_quo     (w_quo),
        .o_rem     (w_rem)
    );

    // HI/LO registers: a completing divide takes priority over an ALU write
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hilo <= {HILO_W{1'b0}};
        end else if (w_div_wr) begin
            r_hilo[HI_MSB:HI_LSB] <= w_rem;
            r_hilo[LO_MSB:LO_LSB] <= w_quo;
        end else if (hilo_we) begin
            r_hilo <= hilo_wdata;
        end else begin
            r_hilo <= r_hilo;
        end
    end

`ifdef HILO_WR_BYPASS_EN
    assign hilo_out = (hilo_we && !w_in_fix) ? hilo_wdata : r_hilo;
`else
    assign hilo_out = r_hilo;
`endif

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed self-checking bench for hilo_div_unit (default build, no write bypass).
module tb_hilo_div_unit;

    logic        clk;
    logic        rst;
    logic        hilo_we;
    logic [63:0] hilo_wdata;
    logic        div_start;
    logic        div_signed;
    logic [31:0] div_a;
    logic [31:0] div_b;
    logic        flush;
    logic [63:0] hilo_out;
    logic        div_busy;
    logic        div_done;
    logic        div_by_zero;

    int n_checks = 0;
    int n_pass   = 0;

    hilo_div_unit #(.DIV_W(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .hilo_we     (hilo_we),
        .hilo_wdata  (hilo_wdata),
        .div_start   (div_start),
        .div_signed  (div_signed),
        .div_a       (div_a),
        .div_b       (div_b),
        .flush       (flush),
        .hilo_out    (hilo_out),
        .div_busy    (div_busy),
        .div_done    (div_done),
        .div_by_zero (div_by_zero)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // Issue one divide at a negedge and watch it until div_busy drops.
    // we_at/flush_at/start_at inject a one-cycle event in that busy cycle (1 = PREP).
    task automatic run_div(input string tag, input logic sgn, input logic [31:0] a,
                           input logic [31:0] b, input int we_at, input int flush_at,
                           input int start_at, input int exp_cycles, input int exp_done,
                           input int exp_dbz, input logic [63:0] exp_hilo);
        int cycles = 0;
        int dones  = 0;
        int dbzs   = 0;
        div_start  = 1'b1;
        div_signed = sgn;
        div_a      = a;
        div_b      = b;
        @(negedge clk);
        div_start  = 1'b0;
        while (div_busy === 1'b1 && cycles < 100) begin
            cycles++;
            hilo_we    = (cycles == we_at);
            hilo_wdata = 64'h0000_0000_0000_DEAD;
            flush      = (cycles == flush_at);
            div_start  = (cycles == start_at);
            if (cycles == start_at) begin
                div_a = 32'd1000;
                div_b = 32'd3;
            end
            #1;
            if (div_done === 1'b1) dones++;
            if (div_by_zero === 1'b1) dbzs++;
            @(negedge clk);
        end
        hilo_we   = 1'b0;
        flush     = 1'b0;
        div_start = 1'b0;
        chk({tag, "_busy_cycles"}, 64'(cycles), 64'(exp_cycles));
        chk({tag, "_done_pulses"}, 64'(dones), 64'(exp_done));
        chk({tag, "_dbz_pulses"}, 64'(dbzs), 64'(exp_dbz));
        chk({tag, "_hilo"}, hilo_out, exp_hilo);
        @(negedge clk);
        chk({tag, "_idle_after"}, {63'd0, div_busy}, 64'd0);
    endtask

    initial begin
        rst        = 1'b0;
        hilo_we    = 1'b0;
        hilo_wdata = 64'd0;
        div_start  = 1'b0;
        div_signed = 1'b0;
        div_a      = 32'd0;
        div_b      = 32'd0;
        flush      = 1'b0;
        repeat (2) @(negedge clk);
        chk("reset_hilo", hilo_out, 64'd0);
        chk("reset_busy", {63'd0, div_busy}, 64'd0);
        chk("reset_done", {62'd0, div_done, div_by_zero}, 64'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("post_reset_hilo", hilo_out, 64'd0);

        hilo_we    = 1'b1;
        hilo_wdata = 64'h1111_2222_3333_4444;
        #1;
        chk("write_same_cycle", hilo_out, 64'd0);
        @(negedge clk);
        hilo_we = 1'b0;
        chk("write_next_cycle", hilo_out, 64'h1111_2222_3333_4444);

        run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 0, 0, 0, 34, 1, 0,
                {32'd2, 32'd14});
        run_div("div_m100_7", 1'b1, 32'hFFFF_FF9C, 32'd7, 0, 0, 0, 34, 1, 0,
                {32'hFFFF_FFFE, 32'hFFFF_FFF2});
        run_div("div_min_m1", 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0, 0, 34, 1, 0,
                {32'd0, 32'h8000_0000});

        hilo_we    = 1'b1;
        hilo_wdata = 64'hA5A5_A5A5_5A5A_5A5A;
        @(negedge clk);
        hilo_we = 1'b0;
        chk("preload", hilo_out, 64'hA5A5_A5A5_5A5A_5A5A);
        run_div("div_by_zero", 1'b1, 32'd123, 32'd0, 0, 0, 0, 2, 1, 1,
                64'hA5A5_A5A5_5A5A_5A5A);

        run_div("flush_run10", 1'b0, 32'd50, 32'd5, 0, 11, 0, 11, 0, 0,
                64'hA5A5_A5A5_5A5A_5A5A);
        run_div("divu_50_5", 1'b0, 32'd50, 32'd5, 0, 0, 0, 34, 1, 0,
                {32'd0, 32'd10});

        run_div("fix_we_start_ign", 1'b0, 32'd9, 32'd2, 34, 0, 20, 34, 1, 0,
                {32'd1, 32'd4});
        run_div("flush_in_fix", 1'b0, 32'd7, 32'd2, 0, 34, 0, 34, 0, 0,
                {32'd1, 32'd4});

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
